// File: rtl/present_pkg.sv
// Shared PRESENT definitions: widths, the 4-bit S-box and the key-schedule state encoding.
// Used by the key schedule, the round datapath and the decryption key scheduler.
package present_pkg;

    localparam int KEY_W = 80;
    localparam int RK_W  = 64;
    localparam int N_RK  = 32;
    localparam int RND_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/present80_key_update.sv
// One PRESENT-80 key-register update step: rotate left 61, S-box the top nibble,
// XOR the round counter into bits [19:15]. Purely combinational.
module present80_key_update
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [4:0]       rc,
    output logic [KEY_W-1:0] key_next
);

    // NOTE: combinational logic uses blocking '=' so each step sees the previous one;
    // clocked state elsewhere uses '<=' so all flops update from the same pre-edge values.
    always_comb begin
        key_next          = {key[18:0], key[79:19]};
        key_next[79:76]   = sbox4(key_next[79:76]);
        key_next[19:15]   = key_next[19:15] ^ rc;
    end

endmodule

// File: rtl/present80_key_sched.sv
// Iterative PRESENT-80 key schedule: loads a user key and streams round keys K1..K32
// over a valid/ready handshake, advancing the key register once per accepted key.
module present80_key_sched
    import present_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  round_key,
    output logic [4:0]       round_idx,
    output logic             rk_last,
    output logic             busy,
    output logic             done
);

    localparam logic [RND_W-1:0] RND_FIRST = RND_W'(1);
    localparam logic [RND_W-1:0] RND_LAST  = RND_W'(N_RK);

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_state_q, key_state_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic               rk_valid_q, rk_valid_d;
    logic               done_q, done_d;
    logic [KEY_W-1:0]   key_upd;
    logic               handshake;
    logic               at_last;

    assign handshake = rk_valid_q & rk_ready;
    assign at_last   = (rnd_q == RND_LAST);

    present80_key_update u_key_update (
        .key      (key_state_q),
        .rc       (rnd_q[4:0]),
        .key_next (key_upd)
    );

    // NOTE: every register, key state included, takes a defined reset value; there is no
    // memory array here, so nothing is left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start)                state_d = RUN;
            RUN:  if (handshake && at_last) state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // NOTE: every variable gets a hold/default value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        key_state_d = key_state_q;
        rnd_d       = rnd_q;
        rk_valid_d  = rk_valid_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_state_d = key_in;
                    rnd_d       = RND_FIRST;
                    rk_valid_d  = 1'b1;
                end
            end
            RUN: begin
                if (handshake) begin
                    if (at_last) begin
                        rk_valid_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        key_state_d = key_upd;
                        rnd_d       = rnd_q + RND_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state_q <= '0;
            rnd_q       <= RND_FIRST;
            rk_valid_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            key_state_q <= key_state_d;
            rnd_q       <= rnd_d;
            rk_valid_q  <= rk_valid_d;
            done_q      <= done_d;
        end
    end

    // The round key comes straight from the key register, never from key_in or rk_ready.
    always_comb begin
        busy      = (state_q == RUN);
        rk_valid  = rk_valid_q;
        round_key = key_state_q[KEY_W-1:KEY_W-RK_W];
        round_idx = rnd_q[4:0] - 5'd1;
        rk_last   = at_last & rk_valid_q;
        done      = done_q;
    end

endmodule

// File: doc/present80_key_sched.md
Name: present80_key_sched

Overview:
- Iterative PRESENT-80 key schedule that feeds the 80-bit key register stage.
- Loads a user key, then emits the 32 round keys K1..K32, one per accepted handshake, on a valid/ready stream.
- The round-key update is applied once per accepted key: rotate, S-box, counter XOR.
- Downstream is the round datapath (addRoundKey); upstream is the key-load control.

Parameters:
- KEY_W, 80, user key / key state width (fixed for PRESENT-80)
- RK_W, 64, round key width, taken from key state bits [79:16]
- N_RK, 32, number of round keys emitted (K1..K32)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  load key_in and begin a schedule; honoured only in IDLE
- key_in  in  80  user key, sampled on the accepted start
- rk_valid  out  1  round_key/round_idx valid
- rk_ready  in  1  consumer accepts the current round key
- round_key  out  64  current round key Ki = key_state[79:16]
- round_idx  out  5  i-1 for Ki (0..31)
- rk_last  out  1  high while K32 is presented
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse after K32 is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, key_state=0, rnd=1, rk_valid=0, round_key=0, round_idx=0, rk_last=0, busy=0, done=0.
- States: IDLE and RUN.
- IDLE & start:
  - key_state<=key_in, rnd<=1, state<=RUN.
  - rk_valid rises the next cycle, i.e. 1-cycle latency, with round_key=key_in[79:16].
- RUN, handshake = rk_valid & rk_ready:
  - rnd<32: key_state<=upd(key_state, rnd), rnd<=rnd+1. The next key is valid the following cycle, so with rk_ready held high one key is emitted per cycle.
  - rnd==32: state<=IDLE, rk_valid<=0, done<=1 for one cycle.
- RUN & !rk_ready: key_state, rnd, round_key and rk_valid all hold. No key may be lost or skipped.
- Once rk_valid is high, it never drops before the handshake.
- upd(k, c), computed in this order:
  1. k' = {k[18:0], k[79:19]} (rotate left 61).
  2. k'[79:76] = S(k'[79:76]).
  3. k'[19:15] ^= c[4:0].
- S-box S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 for inputs 0..F.
- Outputs: round_idx = rnd-1; rk_last = (rnd==32) & rk_valid; busy = (state==RUN).
- rnd is a 6-bit counter, 1..32, and never wraps; the XOR uses its low 5 bits, values 1..31 only.
- start while busy: ignored. The schedule continues and key_in is not sampled.
- start asserted in the done cycle: accepted, since the state is already IDLE.
- rst mid-schedule: immediate return to reset values. No done pulse. A new start is required afterwards.
- round_key is driven from key_state only (no combinational path from key_in or rk_ready).

Decomposition:
- Shared package present_pkg holds:
  - the 16x4 PRESENT S-box constant and an sbox4 function;
  - KEY_W=80, RK_W=64, N_RK=32;
  - the state enum {IDLE, RUN}.
- Sub-module present80_key_update: purely combinational, ports key[79:0], rc[4:0] -> key_next[79:0]. The round datapath and a later on-the-fly decryption key scheduler reuse it.

Test Plan:
- Zero key, rk_ready=1:
  - start with key_in=0 -> K1=0000000000000000 (idx 0), K2=C000000000000000, K3=5000180000000001 on consecutive cycles.
  - K32=6DAB31744F41D700 with rk_last=1; done pulses exactly one cycle after it; exactly 32 handshakes in total.
- All-ones key:
  - start with key_in=FFFF_FFFFFFFF_FFFFFFFF -> K1=FFFFFFFFFFFFFFFF.
  - All 32 keys match the software model.
- Back-pressure:
  - drop rk_ready pseudo-randomly, including 10 consecutive low cycles at K7 -> round_key and idx hold stable.
  - The sequence is identical to the rk_ready=1 run; no duplicates or skips.
- Ignored start: pulse start with a different key_in at K10 -> no effect; K11..K32 unchanged.
- Reset mid-run:
  - assert rst asynchronously at K15 -> all outputs 0 immediately, no done pulse.
  - A fresh start with the zero key reproduces K1=0.
- Back-to-back schedules: start in the done cycle with the all-ones key -> K1=FFFFFFFFFFFFFFFF one cycle later.
